// File: rtl/wr_fifo_pack_if.sv
// Handshake bundle for wr_fifo_pack: narrow word input side and wide beat output side.
// Flush/rd_words signals exist only when WR_FIFO_PACK_FLUSH_EN is defined.
interface wr_fifo_pack_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  parameter int DEPTH     = 4
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW    = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);

  logic                 wr_en;
  logic [IN_WIDTH-1:0]  wr_data;
  logic                 wr_rdy;
  logic                 rd_en;
  logic                 rd_vld;
  logic [OUT_WIDTH-1:0] rd_data;
  logic [AW:0]          beat_cnt;
`ifdef WR_FIFO_PACK_FLUSH_EN
  logic                 flush;
  logic [CW:0]          rd_words;

  modport master (output wr_en, wr_data, rd_en, flush,
                  input  wr_rdy, rd_vld, rd_data, beat_cnt, rd_words);
  modport slave  (input  wr_en, wr_data, rd_en, flush,
                  output wr_rdy, rd_vld, rd_data, beat_cnt, rd_words);
`else
  modport master (output wr_en, wr_data, rd_en,
                  input  wr_rdy, rd_vld, rd_data, beat_cnt);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output wr_rdy, rd_vld, rd_data, beat_cnt);
`endif
endinterface

// File: rtl/wr_fifo_pack.sv
// Packs RATIO narrow words (first word in LSBs) into wide beats, buffered DEPTH deep, FWFT; beat visible 1 cycle after last word.
// Stalls only the beat-completing word while full (no rd_en path to wr_rdy); WR_FIFO_PACK_FLUSH_EN adds flush/rd_words.
module wr_fifo_pack #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  parameter int DEPTH     = 4
) (
  input  logic           clk,
  input  logic           rst,
  wr_fifo_pack_if.slave  bus
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW    = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);

  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] pack;
  logic [OUT_WIDTH-1:0] merged;
  logic [OUT_WIDTH-1:0] beat;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          beat_cnt_q;
  logic                 full;
  logic                 last;
  logic                 wr_acc;
  logic                 push;
  logic                 pop;

  assign full        = (beat_cnt_q == (AW+1)'(DEPTH));
  assign last        = (cnt == CW'(RATIO-1));
  assign bus.wr_rdy  = ~full | ~last;
  assign wr_acc      = bus.wr_en & bus.wr_rdy;
  assign bus.rd_vld  = (beat_cnt_q != '0);
  assign pop         = bus.rd_en & bus.rd_vld;
  assign bus.rd_data = mem[rptr];
  assign bus.beat_cnt = beat_cnt_q;

  // Current word merged into its slot; only committed to pack when accepted.
  always_comb begin
    merged = pack;
    merged[cnt*IN_WIDTH +: IN_WIDTH] = bus.wr_data;
  end

`ifdef WR_FIFO_PACK_FLUSH_EN
  logic [CW:0] fill;
  logic        flush_acc;
  logic [CW:0] words_mem [DEPTH];

  assign fill      = {1'b0, cnt} + (CW+1)'(wr_acc);
  assign flush_acc = bus.flush & ~full;
  assign push      = (wr_acc & last) | (flush_acc & (fill != '0));
  assign bus.rd_words = words_mem[rptr];

  // Slots beyond the words actually collected hold stale data and are zeroed.
  always_comb begin
    beat = merged;
    for (int i = 0; i < RATIO; i++) begin
      if (i >= int'(fill)) beat[i*IN_WIDTH +: IN_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) words_mem[wptr] <= fill;
  end
`else
  assign push = wr_acc & last;
  assign beat = merged;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) pack <= merged;
    if (push)   mem[wptr] <= beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (push)        cnt <= '0;
      else if (wr_acc) cnt <= cnt + CW'(1);
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   beat_cnt_q <= beat_cnt_q + (AW+1)'(1);
        2'b01:   beat_cnt_q <= beat_cnt_q - (AW+1)'(1);
        default: beat_cnt_q <= beat_cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_fifo_pack.sv
// Directed bench for wr_fifo_pack: reset, packing order, full stall, pop/push collision, streaming, mid-run reset, flush.
module tb_wr_fifo_pack;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wr_fifo_pack_if bus ();
  wr_fifo_pack dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [127:0] mk_beat(input logic [15:0] base);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[k*16 +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
`ifdef WR_FIFO_PACK_FLUSH_EN
    bus.flush   = 1'b0;
`endif
  endtask

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = base + 16'(i);
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b want 0", bus.rd_vld); end
    checks++; if (bus.beat_cnt !== 3'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", bus.beat_cnt); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy: got %b want 1", bus.wr_rdy); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'(i + 1);
      step();
      if (i == 6) begin
        checks++; if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld: got %b want 0", bus.rd_vld); end
      end
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.rd_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", bus.rd_vld); end
    checks++; if (bus.rd_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
      errors++; $display("FAIL single_data: got %h want 00080007000600050004000300020001", bus.rd_data); end
    checks++; if (bus.beat_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", bus.beat_cnt); end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL single_pop_vld: got %b want 0", bus.rd_vld); end
    checks++; if (bus.beat_cnt !== 3'd0) begin errors++; $display("FAIL single_pop_cnt: got %0d want 0", bus.beat_cnt); end
  endtask

  task automatic test_full_stall();
    write_words(16'h1000, 32);
    checks++; if (bus.beat_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt: got %0d want 4", bus.beat_cnt); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_cnt0: got %b want 1", bus.wr_rdy); end
    write_words(16'h1020, 7);
    checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_cnt7: got %b want 0", bus.wr_rdy); end
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h1027;
    step();
    checks++; if (bus.beat_cnt !== 3'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", bus.beat_cnt); end
    checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy: got %b want 0", bus.wr_rdy); end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    checks++; if (bus.beat_cnt !== 3'd3) begin errors++; $display("FAIL after_pop_cnt: got %0d want 3", bus.beat_cnt); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL after_pop_rdy: got %b want 1", bus.wr_rdy); end
    step();
    bus.wr_en = 1'b0;
    checks++; if (bus.beat_cnt !== 3'd4) begin errors++; $display("FAIL complete_cnt: got %0d want 4", bus.beat_cnt); end
    for (int b = 1; b <= 4; b++) begin
      checks++; if (bus.rd_data !== mk_beat(16'h1000 + 16'(b*8))) begin
        errors++; $display("FAIL full_drain_%0d: got %h want %h", b, bus.rd_data, mk_beat(16'h1000 + 16'(b*8))); end
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got %b want 0", bus.rd_vld); end
  endtask

  task automatic test_pop_push_same();
    write_words(16'h3000, 32);
    write_words(16'h3020, 7);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h3027;
    bus.rd_en   = 1'b1;
    checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL same_rdy: got %b want 0", bus.wr_rdy); end
    step();
    bus.rd_en = 1'b0;
    checks++; if (bus.beat_cnt !== 3'd3) begin errors++; $display("FAIL same_cnt3: got %0d want 3", bus.beat_cnt); end
    step();
    bus.wr_en = 1'b0;
    checks++; if (bus.beat_cnt !== 3'd4) begin errors++; $display("FAIL same_cnt4: got %0d want 4", bus.beat_cnt); end
    for (int b = 1; b <= 4; b++) begin
      checks++; if (bus.rd_data !== mk_beat(16'h3000 + 16'(b*8))) begin
        errors++; $display("FAIL same_drain_%0d: got %h want %h", b, bus.rd_data, mk_beat(16'h3000 + 16'(b*8))); end
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int nb   = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (sent >= 64 && !bus.rd_vld) break;
      bus.wr_en   = (sent < 64);
      bus.wr_data = 16'h2000 + 16'(sent);
      bus.rd_en   = 1'b1;
      if (bus.rd_vld) begin
        checks++; if (bus.rd_data !== mk_beat(16'h2000 + 16'(nb*8))) begin
          errors++; $display("FAIL b2b_beat_%0d: got %h want %h", nb, bus.rd_data, mk_beat(16'h2000 + 16'(nb*8))); end
        nb++;
      end
      if (bus.wr_en && bus.wr_rdy) sent++;
      step();
    end
    idle();
    checks++; if (nb !== 8) begin errors++; $display("FAIL b2b_count: got %0d beats want 8", nb); end
    checks++; if (bus.beat_cnt !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", bus.beat_cnt); end
  endtask

  task automatic test_reset_mid();
    write_words(16'h4000, 21);
    checks++; if (bus.beat_cnt !== 3'd2) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 2", bus.beat_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL mid_rd_vld: got %b want 0", bus.rd_vld); end
    checks++; if (bus.beat_cnt !== 3'd0) begin errors++; $display("FAIL mid_beat_cnt: got %0d want 0", bus.beat_cnt); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL mid_wr_rdy: got %b want 1", bus.wr_rdy); end
    write_words(16'h5000, 8);
    checks++; if (bus.rd_data !== mk_beat(16'h5000)) begin
      errors++; $display("FAIL mid_first_beat: got %h want %h", bus.rd_data, mk_beat(16'h5000)); end
    checks++; if (bus.beat_cnt !== 3'd1) begin errors++; $display("FAIL mid_post_cnt: got %0d want 1", bus.beat_cnt); end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

`ifdef WR_FIFO_PACK_FLUSH_EN
  task automatic test_flush();
    logic [127:0] exp;
    write_words(16'h000A, 3);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    exp = 128'h0000_0000_0000_0000_0000_000C_000B_000A;
    checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL flush_data: got %h want %h", bus.rd_data, exp); end
    checks++; if (bus.rd_words !== 4'd3) begin errors++; $display("FAIL flush_words: got %0d want 3", bus.rd_words); end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    write_words(16'h000D, 1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h000E;
    bus.flush   = 1'b1;
    step();
    idle();
    exp = 128'h0000_0000_0000_0000_0000_0000_000E_000D;
    checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL flush_wr_data: got %h want %h", bus.rd_data, exp); end
    checks++; if (bus.rd_words !== 4'd2) begin errors++; $display("FAIL flush_wr_words: got %0d want 2", bus.rd_words); end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_beat();
    test_full_stall();
    test_pop_push_same();
    test_back_to_back();
    test_reset_mid();
`ifdef WR_FIFO_PACK_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
